// File: rtl/adc_channel_scanner.sv
// adc_channel_scanner: round-robin scan sequencer for the modular ADC.
// Issues one command at a time, averages 2^AVG_LOG2 samples per slot and
// publishes a millivolt value per slot, live and as a periodic snapshot.
// Ports:
//   clk, reset             system clock, synchronous active-high reset
//   o_cmd_*  / i_cmd_ready ADC command stream (sop/eop tied high)
//   i_rsp_*                ADC response stream (valid, channel, 12-bit code)
//   o_mv_live              per-slot mV, slot i at [i*OUT_W +: OUT_W]
//   o_mv_held              snapshot of o_mv_live every UPDATE_DIV cycles
//   o_held_strobe          one-cycle pulse when o_mv_held updates
//   o_sample_err           one-cycle pulse on timeout/mismatch/unsolicited
module adc_channel_scanner #(
    parameter int NUM_CH        = 3,
    parameter int CH_BASE       = 1,
    parameter int AVG_LOG2      = 2,
    parameter int FULL_SCALE_MV = 5000,
    parameter int OUT_W         = 13,
    parameter int UPDATE_DIV    = 250000,
    parameter int TIMEOUT       = 1023
) (
    input  logic                    clk,
    input  logic                    reset,
    output logic                    o_cmd_valid,
    output logic [4:0]              o_cmd_channel,
    output logic                    o_cmd_sop,
    output logic                    o_cmd_eop,
    input  logic                    i_cmd_ready,
    input  logic                    i_rsp_valid,
    input  logic [4:0]              i_rsp_channel,
    input  logic [11:0]             i_rsp_data,
    output logic [NUM_CH*OUT_W-1:0] o_mv_live,
    output logic [NUM_CH*OUT_W-1:0] o_mv_held,
    output logic                    o_held_strobe,
    output logic                    o_sample_err
);
    localparam int SW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int AW = 12 + AVG_LOG2;
    localparam int CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam int DW = $clog2(UPDATE_DIV);

    localparam logic [SW-1:0] SLOT_LAST = SW'(NUM_CH - 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'((1 << AVG_LOG2) - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);
    localparam logic [DW-1:0] DIV_LAST  = DW'(UPDATE_DIV - 1);
    localparam logic [63:0]   MV_MAX    = (64'd1 << OUT_W) - 64'd1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t                  r_state;
    logic [SW-1:0]           r_slot;
    logic [WW-1:0]           r_wcnt;
    logic                    r_cmd_valid;
    logic [4:0]              r_cmd_ch;
    logic                    r_err;
    logic [AW-1:0]           r_acc [NUM_CH];
    logic [CW-1:0]           r_cnt [NUM_CH];
    logic                    r_avg_vld;
    logic [SW-1:0]           r_avg_slot;
    logic [11:0]             r_avg;
    logic [NUM_CH*OUT_W-1:0] r_live;
    logic [NUM_CH*OUT_W-1:0] r_held;
    logic [DW-1:0]           r_div;
    logic                    r_strobe;

    logic [SW-1:0]    w_slot_nxt;
    logic             w_in_wait;
    logic             w_match;
    logic             w_accept;
    logic             w_timeout;
    logic             w_done;
    logic             w_err;
    logic [AW-1:0]    w_sum;
    logic [63:0]      w_prod;
    logic [63:0]      w_quot;
    logic [OUT_W-1:0] w_mv;

    assign w_slot_nxt = (r_slot == SLOT_LAST) ? '0 : r_slot + 1'b1;
    assign w_in_wait  = (r_state == WAIT);
    assign w_match    = (i_rsp_channel == r_cmd_ch);
    assign w_accept   = w_in_wait && i_rsp_valid && w_match;
    assign w_timeout  = w_in_wait && !i_rsp_valid && (r_wcnt == WAIT_LAST);
    assign w_done     = w_in_wait && (i_rsp_valid || w_timeout);
    // Any response not matching the single outstanding command is an error.
    assign w_err      = (i_rsp_valid && (!w_in_wait || !w_match)) || w_timeout;
    assign w_sum      = r_acc[r_slot] + AW'(i_rsp_data);
    assign w_prod     = 64'(r_avg) * 64'(FULL_SCALE_MV);
    assign w_quot     = w_prod / 64'd4095;
    assign w_mv       = (w_quot > MV_MAX) ? OUT_W'(MV_MAX) : OUT_W'(w_quot);

    // Command handshake FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_slot      <= '0;
            r_wcnt      <= '0;
            r_cmd_valid <= 1'b0;
            r_cmd_ch    <= 5'(CH_BASE);
            r_err       <= 1'b0;
        end else begin
            r_err <= w_err;
            unique case (r_state)
                IDLE: begin
                    r_state     <= ISSUE;
                    r_cmd_valid <= 1'b1;
                end
                ISSUE: begin
                    if (i_cmd_ready) begin
                        r_state     <= WAIT;
                        r_cmd_valid <= 1'b0;
                        r_wcnt      <= '0;
                    end
                end
                WAIT: begin
                    if (w_done) begin
                        r_state     <= ISSUE;
                        r_cmd_valid <= 1'b1;
                        r_slot      <= w_slot_nxt;
                        r_cmd_ch    <= 5'(CH_BASE) + 5'(w_slot_nxt);
                    end else begin
                        r_wcnt <= r_wcnt + 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_cmd_valid <= 1'b0;
                end
            endcase
        end
    end

    // Stage 1: per-slot accumulate, emit average on the last sample
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_acc[i] <= '0;
                r_cnt[i] <= '0;
            end
            r_avg_vld  <= 1'b0;
            r_avg_slot <= '0;
            r_avg      <= '0;
        end else begin
            r_avg_vld <= 1'b0;
            if (w_accept) begin
                if (r_cnt[r_slot] == CNT_LAST) begin
                    r_acc[r_slot] <= '0;
                    r_cnt[r_slot] <= '0;
                    r_avg         <= 12'(w_sum >> AVG_LOG2);
                    r_avg_vld     <= 1'b1;
                    r_avg_slot    <= r_slot;
                end else begin
                    r_acc[r_slot] <= w_sum;
                    r_cnt[r_slot] <= r_cnt[r_slot] + 1'b1;
                end
            end
        end
    end

    // Stage 2: scale to mV and update only the completing slot
    always_ff @(posedge clk) begin
        if (reset) begin
            r_live <= '0;
        end else if (r_avg_vld) begin
            r_live[r_avg_slot*OUT_W +: OUT_W] <= w_mv;
        end
    end

    // Snapshot divider; capture uses the pre-update live value
    always_ff @(posedge clk) begin
        if (reset) begin
            r_div    <= '0;
            r_held   <= '0;
            r_strobe <= 1'b0;
        end else begin
            r_strobe <= (r_div == DIV_LAST);
            if (r_div == DIV_LAST) begin
                r_div  <= '0;
                r_held <= r_live;
            end else begin
                r_div <= r_div + 1'b1;
            end
        end
    end

    assign o_cmd_valid   = r_cmd_valid;
    assign o_cmd_channel = r_cmd_ch;
    assign o_cmd_sop     = 1'b1;
    assign o_cmd_eop     = 1'b1;
    assign o_mv_live     = r_live;
    assign o_mv_held     = r_held;
    assign o_held_strobe = r_strobe;
    assign o_sample_err  = r_err;
endmodule
